// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
//   Shared definitions for the tile sequencing logic:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - tile size and phase-length helpers
//   - counter-width helper
// ---------------------------------------------------------------------------
package tpu_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FILL = 3'd1;
   localparam logic [2:0] ST_LOAD = 3'd2;
   localparam logic [2:0] ST_GAP  = 3'd3;
   localparam logic [2:0] ST_INIT = 3'd4;
   localparam logic [2:0] ST_XFER = 3'd5;
   localparam logic [2:0] ST_WAIT = 3'd6;
   localparam logic [2:0] ST_DONE = 3'd7;

   // Word pairs per tile.
   function automatic int tile_words(input int n);
      return n * n;
   endfunction

   // Transfer window: the loader's read pipeline needs N+1 cycles to drain.
   function automatic int xfer_cycles(input int n);
      return n + 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width of a counter that must hold 0..v-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//   Parallel-in / serial-out shift register, LSB first.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     i_load       capture i_din (takes priority over i_shift)
//     i_shift      shift right by one, zero-filling the MSB
//     i_din[D_W]   parallel word
//     o_bit        current serial bit (register bit 0)
// ---------------------------------------------------------------------------
module word_serializer #(
   parameter int D_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_load,
   input  logic           i_shift,
   input  logic [D_W-1:0] i_din,
   output logic           o_bit
);

   logic [D_W-1:0] r_sr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_sr <= '0;
      else if (i_load)  r_sr <= i_din;
      else if (i_shift) r_sr <= {1'b0, r_sr[D_W-1:1]};
   end

   assign o_bit = r_sr[0];

endmodule

// File: rtl/tile_sequencer.sv
// ---------------------------------------------------------------------------
// tile_sequencer
//   Buffers N*N host (x,y) word pairs, streams them LSB-first on ser_x/ser_y
//   under load_en, pulses init to launch the array transfer, waits the
//   transfer and compute windows and pulses done.
//   Ports:
//     clk, rst_n            clock / async active-low reset
//     wr_valid/wr_ready     host word-pair handshake
//     wr_x, wr_y [D_W]      operand words
//     abort                 synchronous return to IDLE from any state
//     load_en, ser_x, ser_y serial operand stream to the loader
//     init                  one-cycle transfer launch
//     busy                  state != IDLE
//     done                  one-cycle tile-complete pulse
//     cycle_cnt [32]        (TILE_SEQ_PERF_EN only) LOAD-to-DONE cycle count
//   Build option: define TILE_SEQ_PERF_EN to add the cycle_cnt counter/port.
// ---------------------------------------------------------------------------
module tile_sequencer import tpu_pkg::*; #(
   parameter int D_W      = 8,
   parameter int N        = 2,
   parameter int GAP_CYC  = 2,
   parameter int COMP_CYC = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [D_W-1:0] wr_x,
   input  logic [D_W-1:0] wr_y,
   input  logic           abort,
   output logic           load_en,
   output logic           ser_x,
   output logic           ser_y,
   output logic           init,
   output logic           busy,
   output logic           done
`ifdef TILE_SEQ_PERF_EN
   ,
   output logic [31:0]    cycle_cnt
`endif
);

   localparam int TILE_WORDS = tile_words(N);
   localparam int XFER_CYC   = xfer_cycles(N);
   localparam int BI_W       = cnt_w(D_W);
   localparam int WI_W       = $clog2(TILE_WORDS + 1);
   localparam int AW         = cnt_w(TILE_WORDS);
   localparam int PH_W       = cnt_w(max3(GAP_CYC, XFER_CYC, COMP_CYC));

   logic [2:0]      r_state;
   logic [WI_W-1:0] r_count;
   logic [WI_W-1:0] r_word;
   logic [BI_W-1:0] r_bit;
   logic [PH_W-1:0] r_phase;
   logic            r_lead;     // high during the lead-in cycle of LOAD
   logic [D_W-1:0]  r_buf_x [TILE_WORDS];
   logic [D_W-1:0]  r_buf_y [TILE_WORDS];

   logic            w_accept;
   logic            w_in_load;
   logic            w_last_bit;
   logic            w_last_word;
   logic            w_ser_load;
   logic            w_ser_shift;
   logic [AW-1:0]   w_ld_idx;
   logic [AW-1:0]   w_wr_idx;
   logic            w_sx;
   logic            w_sy;

   // abort wins over a write presented in the same cycle
   assign w_accept    = wr_valid && wr_ready && !abort;
   assign w_in_load   = (r_state == ST_LOAD);
   assign w_last_bit  = (r_bit == BI_W'(D_W - 1));
   assign w_last_word = (r_word == WI_W'(TILE_WORDS - 1));

   // The serializers are loaded at the end of the lead-in cycle and at the end
   // of each word's last bit, so the bit stream never stalls between words.
   assign w_ser_load  = w_in_load && (r_lead || (w_last_bit && !w_last_word));
   assign w_ser_shift = w_in_load && !w_ser_load;
   assign w_ld_idx    = r_lead ? '0 : AW'(r_word + 1'b1);
   assign w_wr_idx    = AW'(r_count);

   // NOTE: the operand buffer has no reset; every entry is written before it
   // is read, and leaving it out keeps it mappable to plain storage.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf_x[w_wr_idx] <= wr_x;
         r_buf_y[w_wr_idx] <= wr_y;
      end
   end

   word_serializer #(.D_W(D_W)) u_ser_x (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_ser_load),
      .i_shift (w_ser_shift),
      .i_din   (r_buf_x[w_ld_idx]),
      .o_bit   (w_sx)
   );

   word_serializer #(.D_W(D_W)) u_ser_y (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_ser_load),
      .i_shift (w_ser_shift),
      .i_din   (r_buf_y[w_ld_idx]),
      .o_bit   (w_sy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_word  <= '0;
         r_bit   <= '0;
         r_phase <= '0;
         r_lead  <= 1'b0;
      end else if (abort) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_word  <= '0;
         r_bit   <= '0;
         r_phase <= '0;
         r_lead  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FILL: begin
               if (w_accept) begin
                  r_count <= r_count + 1'b1;
                  r_lead  <= 1'b1;
                  if (r_count == WI_W'(TILE_WORDS - 1)) r_state <= ST_LOAD;
                  else                                  r_state <= ST_FILL;
               end
            end
            ST_LOAD: begin
               if (r_lead) begin
                  r_lead <= 1'b0;
                  r_word <= '0;
                  r_bit  <= '0;
               end else if (w_last_bit) begin
                  r_bit <= '0;
                  if (w_last_word) begin
                     r_state <= ST_GAP;
                     r_phase <= '0;
                  end else begin
                     r_word <= r_word + 1'b1;
                  end
               end else begin
                  r_bit <= r_bit + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_phase == PH_W'(GAP_CYC - 1)) begin
                  r_state <= ST_INIT;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_INIT: begin
               r_state <= ST_XFER;
               r_phase <= '0;
            end
            ST_XFER: begin
               if (r_phase == PH_W'(XFER_CYC - 1)) begin
                  r_state <= ST_WAIT;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_WAIT: begin
               if (r_phase == PH_W'(COMP_CYC - 1)) begin
                  r_state <= ST_DONE;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_count <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode from registered state, so reset/abort return them to
   // their idle values without extra clearing logic.
   assign wr_ready = ((r_state == ST_IDLE) || (r_state == ST_FILL))
                     && (r_count < WI_W'(TILE_WORDS));
   assign load_en  = w_in_load && (r_lead || !(w_last_bit && w_last_word));
   assign ser_x    = w_in_load && !r_lead && w_sx;
   assign ser_y    = w_in_load && !r_lead && w_sy;
   assign init     = (r_state == ST_INIT);
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);

`ifdef TILE_SEQ_PERF_EN
   logic [31:0] r_perf_acc;
   logic [31:0] r_cycle_cnt;

   // r_perf_acc counts LOAD..WAIT; the DONE cycle itself is added at the latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_acc  <= '0;
         r_cycle_cnt <= '0;
      end else if (abort) begin
         r_perf_acc  <= '0;
         r_cycle_cnt <= '0;
      end else begin
         case (r_state)
            ST_LOAD, ST_GAP, ST_INIT, ST_XFER, ST_WAIT:
               r_perf_acc <= r_perf_acc + 32'd1;
            ST_DONE: begin
               r_cycle_cnt <= r_perf_acc + 32'd1;
               r_perf_acc  <= '0;
            end
            default: r_perf_acc <= '0;
         endcase
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tile_sequencer
//   Directed bench for tile_sequencer (D_W=8, N=2, GAP_CYC=2, COMP_CYC=8).
//   Accepted writes push their expected serial bits to scoreboard queues;
//   the LOAD window pops and compares them bit by bit. Phase timing is
//   checked against fixed cycle counts.
// ---------------------------------------------------------------------------
module tb_tile_sequencer;

   localparam int D_W   = 8;
   localparam int K     = 4 * D_W;       // bits per tile
   localparam int WAITS = 3 + 8;         // XFER + WAIT cycles between init and done
   localparam int PERF  = K + 1 + 2 + 1 + 3 + 8 + 1;

   logic           clk;
   logic           rst_n;
   logic           wr_valid;
   logic           wr_ready;
   logic [D_W-1:0] wr_x;
   logic [D_W-1:0] wr_y;
   logic           abort;
   logic           load_en;
   logic           ser_x;
   logic           ser_y;
   logic           init;
   logic           busy;
   logic           done;
`ifdef TILE_SEQ_PERF_EN
   logic [31:0]    cycle_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;
   bit q_x[$];
   bit q_y[$];

   tile_sequencer #(.D_W(8), .N(2), .GAP_CYC(2), .COMP_CYC(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .abort     (abort),
      .load_en   (load_en),
      .ser_x     (ser_x),
      .ser_y     (ser_y),
      .init      (init),
      .busy      (busy),
      .done      (done)
`ifdef TILE_SEQ_PERF_EN
      ,
      .cycle_cnt (cycle_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pair(input logic [D_W-1:0] x, input logic [D_W-1:0] y);
      check("wr_ready_before_write", wr_ready, 1);
      wr_valid = 1'b1;
      wr_x     = x;
      wr_y     = y;
      for (int b = 0; b < D_W; b++) begin
         q_x.push_back(x[b]);
         q_y.push_back(y[b]);
      end
      step();
      wr_valid = 1'b0;
   endtask

   task automatic write_tile(input logic [31:0] xs, input logic [31:0] ys);
      for (int i = 0; i < 4; i++) write_pair(xs[8*i +: 8], ys[8*i +: 8]);
   endtask

   // Entered in cycle L0 (right after the 4th accepted write); leaves in the
   // IDLE cycle following done.
   task automatic run_tile(input bit junk);
      bit ex, ey;
      check("l0_load_en", load_en, 1);
      check("l0_ser", {ser_x, ser_y}, 0);
      check("l0_wr_ready", wr_ready, 0);
      check("l0_busy", busy, 1);
      if (junk) begin
         wr_valid = 1'b1;
         wr_x     = 8'hFF;
         wr_y     = 8'hEE;
      end
      for (int k = 1; k <= K; k++) begin
         step();
         wr_valid = 1'b0;
         if (q_x.size() == 0 || q_y.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            ex = q_x.pop_front();
            ey = q_y.pop_front();
            check("ser_x_bit", ser_x, ex);
            check("ser_y_bit", ser_y, ey);
         end
         check("load_en_bit", load_en, (k < K) ? 1 : 0);
         check("wr_ready_load", wr_ready, 0);
      end
      check("scoreboard_empty", q_x.size() + q_y.size(), 0);
      for (int g = 0; g < 2; g++) begin
         step();
         check("gap_outputs", {load_en, ser_x, ser_y, init, done}, 0);
         check("gap_busy", busy, 1);
      end
      step();
      check("init_pulse", init, 1);
      check("init_load_en", load_en, 0);
      for (int w = 0; w < WAITS; w++) begin
         step();
         check("wait_quiet", {init, done}, 0);
         check("wait_busy", busy, 1);
      end
      step();
      check("done_pulse", done, 1);
      check("done_wr_ready", wr_ready, 0);
      step();
      check("idle_after_done", {done, busy}, 0);
      check("idle_wr_ready", wr_ready, 1);
`ifdef TILE_SEQ_PERF_EN
      check("perf_cycle_cnt", cycle_cnt, PERF);
`endif
   endtask

   initial begin
      rst_n    = 1'b1;
      wr_valid = 1'b0;
      wr_x     = '0;
      wr_y     = '0;
      abort    = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_wr_ready", wr_ready, 1);
      check("reset_outputs", {load_en, ser_x, ser_y, init, busy, done}, 0);
`ifdef TILE_SEQ_PERF_EN
      check("reset_cycle_cnt", cycle_cnt, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset asserted mid-LOAD: outputs drop without waiting for a clock.
      write_tile(32'h04030201, 32'h40302010);
      for (int i = 0; i < 4; i++) step();
      check("midload_load_en_pre", load_en, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midload_rst_load_en", load_en, 0);
      check("midload_rst_busy", busy, 0);
      check("midload_rst_wr_ready", wr_ready, 1);
      q_x.delete();
      q_y.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reference tile; refills from index 0 after the reset.
      write_tile(32'h04030201, 32'h40302010);
      run_tile(1'b0);

      // Backpressure: a 5th pair offered while the tile is full is dropped.
      write_tile(32'h3CA55AC3, 32'h807F0FF0);
      run_tile(1'b1);

      // Abort during XFER, with a write offered in the same cycle.
      write_tile(32'h11223344, 32'h55667788);
      for (int i = 0; i < K + 4; i++) step();
      q_x.delete();
      q_y.delete();
      abort    = 1'b1;
      wr_valid = 1'b1;
      wr_x     = 8'h99;
      wr_y     = 8'h99;
      step();
      abort    = 1'b0;
      wr_valid = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_wr_ready", wr_ready, 1);
      check("abort_outputs", {load_en, ser_x, ser_y, init, done}, 0);
`ifdef TILE_SEQ_PERF_EN
      check("abort_cycle_cnt", cycle_cnt, 0);
`endif
      for (int i = 0; i < 14; i++) begin
         step();
         check("abort_quiet", {init, done, busy}, 0);
      end

      // abort beats a same-cycle write in IDLE: buffer stays empty.
      abort    = 1'b1;
      wr_valid = 1'b1;
      wr_x     = 8'h77;
      wr_y     = 8'h77;
      step();
      abort    = 1'b0;
      wr_valid = 1'b0;
      check("abort_write_dropped", busy, 0);

      // Count restarted at 0: exactly four writes start the next LOAD.
      write_tile(32'hDEADBEEF, 32'h0BADF00D);
      run_tile(1'b0);

      // Back-to-back: the next tile is written in the cycle after done.
      write_tile(32'h80402010, 32'h01020408);
      run_tile(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
